// File: rtl/bram_accessor_mc.sv
// bram_accessor_mc: streams N packed words from BRAM0 through LANES parallel
// arithmetic units (square / mul coef / pass / add coef) and writes the widened
// results to BRAM1, one word per cycle.
// Optional feature macro: BRAM_ACC_PERF_CNT_EN adds perf_cycles_o, a run-length
// cycle counter.
module bram_accessor_mc #(
  parameter int CNT_BIT       = 31,
  parameter int LANES         = 4,
  parameter int IN_DATA_WIDTH = 8,
  parameter int AWIDTH        = 8,
  parameter int RD_LATENCY    = 1,
  localparam int DWIDTH_1     = LANES * IN_DATA_WIDTH,
  localparam int DWIDTH_2     = 2 * DWIDTH_1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_run_i,
  input  logic [CNT_BIT-1:0]       run_count_i,
  input  logic [1:0]               mode_i,
  input  logic [IN_DATA_WIDTH-1:0] coef_i,
  input  logic [AWIDTH-1:0]        src_base_i,
  input  logic [AWIDTH-1:0]        dst_base_i,
  input  logic [DWIDTH_1-1:0]      q_b0_i,
  output logic                     idle_o,
  output logic                     read_o,
  output logic                     write_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [AWIDTH-1:0]        addr_b0_o,
  output logic                     ce_b0_o,
  output logic                     we_b0_o,
  output logic [AWIDTH-1:0]        addr_b1_o,
  output logic                     ce_b1_o,
  output logic                     we_b1_o,
`ifdef BRAM_ACC_PERF_CNT_EN
  output logic [31:0]              perf_cycles_o,
`endif
  output logic [DWIDTH_2-1:0]      d_b1_o
);

  localparam int OW = 2 * IN_DATA_WIDTH;
  // Largest legal run: one full pass over the address space.
  localparam logic [CNT_BIT:0] MaxCnt = (CNT_BIT+1)'(1) << AWIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q;
  logic [AWIDTH:0]          cnt_q;
  logic [AWIDTH:0]          rd_cnt_q;
  logic [AWIDTH:0]          wr_cnt_q;
  logic [1:0]               mode_q;
  logic [IN_DATA_WIDTH-1:0] coef_q;
  logic [AWIDTH-1:0]        src_q;
  logic [AWIDTH-1:0]        dst_q;
  logic [AWIDTH-1:0]        addr_b0_q;
  logic                     ce_b0_q;
  logic                     idle_q;
  logic                     done_q;
  logic                     err_q;
  logic [RD_LATENCY-1:0]    vld_pipe_q;
  logic                     we_b1_q;
  logic [AWIDTH-1:0]        addr_b1_q;
  logic [DWIDTH_2-1:0]      d_b1_q;
  logic [DWIDTH_2-1:0]      res_s;
  logic                     too_big_s;
  logic                     zero_s;
  logic                     accept_s;
  logic                     dat_vld_s;

  // One lane of arithmetic; operands are zero-extended so no result overflows.
  function automatic logic [OW-1:0] lane_op(input logic [1:0] mode,
                                            input logic [IN_DATA_WIDTH-1:0] x,
                                            input logic [IN_DATA_WIDTH-1:0] c);
    logic [OW-1:0] xe;
    logic [OW-1:0] ce;
    logic [OW-1:0] r;
    xe = {{IN_DATA_WIDTH{1'b0}}, x};
    ce = {{IN_DATA_WIDTH{1'b0}}, c};
    case (mode)
      2'd0:    r = xe * xe;
      2'd1:    r = xe * ce;
      2'd2:    r = xe;
      2'd3:    r = xe + ce;
      default: r = xe;
    endcase
    return r;
  endfunction

  assign too_big_s = {1'b0, run_count_i} > MaxCnt;
  assign zero_s    = (run_count_i == {CNT_BIT{1'b0}});
  assign accept_s  = (state_q == S_IDLE) && start_run_i && !too_big_s;
  assign dat_vld_s = vld_pipe_q[RD_LATENCY-1];

  // Combinational lane array over the current BRAM0 read word.
  always_comb begin
    res_s = {DWIDTH_2{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      res_s[i*OW +: OW] = lane_op(mode_q, q_b0_i[i*IN_DATA_WIDTH +: IN_DATA_WIDTH], coef_q);
    end
  end

  // Control FSM: start/reject, read issue, drain wait and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      mode_q    <= 2'd0;
      coef_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      addr_b0_q <= '0;
      ce_b0_q   <= 1'b0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          idle_q  <= 1'b1;
          ce_b0_q <= 1'b0;
          if (start_run_i) begin
            if (too_big_s) begin
              err_q <= 1'b1;
            end else begin
              cnt_q  <= run_count_i[AWIDTH:0];
              mode_q <= mode_i;
              coef_q <= coef_i;
              src_q  <= src_base_i;
              dst_q  <= dst_base_i;
              idle_q <= 1'b0;
              if (zero_s) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_RUN;
                ce_b0_q   <= 1'b1;
                addr_b0_q <= src_base_i;
                rd_cnt_q  <= (AWIDTH+1)'(1);
              end
            end
          end
        end
        S_RUN: begin
          if (rd_cnt_q == cnt_q) begin
            ce_b0_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_b0_q <= src_q + rd_cnt_q[AWIDTH-1:0];
            rd_cnt_q  <= rd_cnt_q + (AWIDTH+1)'(1);
          end
        end
        S_DRAIN: begin
          if (wr_cnt_q == cnt_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          idle_q   <= 1'b1;
          rd_cnt_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write pipeline: tracks read latency, registers lane results and BRAM1 address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      wr_cnt_q   <= '0;
      we_b1_q    <= 1'b0;
      addr_b1_q  <= '0;
      d_b1_q     <= '0;
    end else begin
      vld_pipe_q[0] <= ce_b0_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
      if (dat_vld_s) begin
        we_b1_q   <= 1'b1;
        d_b1_q    <= res_s;
        addr_b1_q <= dst_q + wr_cnt_q[AWIDTH-1:0];
        wr_cnt_q  <= wr_cnt_q + (AWIDTH+1)'(1);
      end else begin
        we_b1_q <= 1'b0;
        if (state_q == S_IDLE) begin
          wr_cnt_q <= '0;
        end
      end
    end
  end

`ifdef BRAM_ACC_PERF_CNT_EN
  logic [31:0] perf_q;

  // Run-length counter: cleared on accepted start, counts every busy cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= 32'd0;
    end else if (accept_s) begin
      perf_q <= 32'd0;
    end else if (state_q != S_IDLE) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

  assign idle_o    = idle_q;
  assign read_o    = ce_b0_q;
  assign write_o   = we_b1_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign addr_b0_o = addr_b0_q;
  assign ce_b0_o   = ce_b0_q;
  assign we_b0_o   = 1'b0;
  assign addr_b1_o = addr_b1_q;
  assign ce_b1_o   = we_b1_q;
  assign we_b1_o   = we_b1_q;
  assign d_b1_o    = d_b1_q;

endmodule

// File: doc/bram_accessor_mc.md
Name: bram_accessor_mc

Overview:
Streams a block of packed words from source BRAM0 through a parametrised array of per-lane arithmetic units and writes the widened results to destination BRAM1.
It is the multi-lane, multi-mode successor of the single-mode BRAM accessor:
- configurable lane count, lane width and BRAM read latency
- selectable operation
- programmable source/destination base addresses
- fully pipelined, one word per cycle
It sits between the register block (start/count/config) and the two BRAM memory interfaces.

Parameters:
CNT_BIT, 31, width of run_count_i
LANES, 4, number of data lanes per word
IN_DATA_WIDTH, 8, bits per input lane; output lane is 2*IN_DATA_WIDTH
AWIDTH, 8, BRAM address width (depth 2^AWIDTH)
RD_LATENCY, 1, BRAM0 read latency in cycles (legal 1 or 2)
(derived) DWIDTH_1 = LANES*IN_DATA_WIDTH; DWIDTH_2 = 2*DWIDTH_1

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous reset, active-low
start_run_i  in  1  start pulse, sampled only in IDLE
run_count_i  in  CNT_BIT  number of words to process
mode_i  in  2  lane op: 0 square, 1 mul coef, 2 pass, 3 add coef
coef_i  in  IN_DATA_WIDTH  coefficient for modes 1/3
src_base_i  in  AWIDTH  first BRAM0 address
dst_base_i  in  AWIDTH  first BRAM1 address
q_b0_i  in  DWIDTH_1  BRAM0 read data
idle_o  out  1  high in IDLE
read_o  out  1  high while issuing reads (RUN)
write_o  out  1  equals we_b1_o
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle pulse on rejected start
addr_b0_o  out  AWIDTH  BRAM0 address
ce_b0_o  out  1  BRAM0 chip enable
we_b0_o  out  1  BRAM0 write enable, tied 0
addr_b1_o  out  AWIDTH  BRAM1 address
ce_b1_o  out  1  BRAM1 chip enable
we_b1_o  out  1  BRAM1 write enable
d_b1_o  out  DWIDTH_2  BRAM1 write data

Behaviour:
- Clocking and reset
  - Single clock. Reset is asynchronous, active-low.
  - On reset: state IDLE, idle_o=1; all other outputs 0; internal counters 0.
  - Reset mid-run aborts immediately with no done_o.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE
  - On start_run_i=1, latch run_count_i, mode_i, coef_i and both bases.
  - run_count_i > 2^AWIDTH: reject; err_o=1 for one cycle, stay IDLE.
  - run_count_i == 0: go directly to DONE; no memory access.
  - Otherwise go to RUN.
- RUN
  - Issue read k (k=0..N-1) one per cycle: addr_b0_o = src_base+k mod 2^AWIDTH, ce_b0_o=1.
  - After read N-1, go to DRAIN.
- Pipeline
  - q_b0_i for read k is valid RD_LATENCY cycles after issue.
  - Lane results are registered one cycle later.
  - Write k: ce_b1_o=we_b1_o=1, addr_b1_o = dst_base+k mod 2^AWIDTH.
  - Write k occurs RD_LATENCY+1 cycles after read k; writes are back-to-back.
- DRAIN: waits for the last write, then goes to DONE. DONE holds done_o=1 for one cycle, then returns to IDLE.
- Timing: with start sampled at edge 0, reads occupy cycles 1..N, writes cycles RD_LATENCY+2..N+RD_LATENCY+1, done_o is in cycle N+RD_LATENCY+2.
- Lane mapping
  - Input lane i = q_b0_i[(i+1)*IN_DATA_WIDTH-1 : i*IN_DATA_WIDTH].
  - Output lane i = d_b1_o[(i+1)*2*IN_DATA_WIDTH-1 : i*2*IN_DATA_WIDTH].
  - Lane 0 is at the LSB.
- Arithmetic (unsigned, never overflows 2*IN_DATA_WIDTH)
  - Mode 0: x*x. Mode 1: x*coef. Mode 2: zero-extend x. Mode 3: x+coef, zero-extended.
- start_run_i outside IDLE is ignored. Config inputs are don't-care after latching.
- Address wrap from 2^AWIDTH-1 to 0 is legal and is not an error.
- d_b1_o and addr_b1_o are held at their last value when we_b1_o=0.

Optional Feature:
- Macro: BRAM_ACC_PERF_CNT_EN.
- When defined:
  - Adds output perf_cycles_o [31:0].
  - Cleared on accepted start, incremented every cycle until and including the done_o cycle.
  - Held until the next accepted start; reset value 0.
  - Rejected starts do not affect it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, mode 0, src=0, dst=0, N=32, BRAM0[k] = lanes {1,3,5,7} (lane3..lane0) -> 32 writes in cycles 3..34, each d_b1_o = 0x0001_0009_0019_0031; done_o in cycle 35; perf_cycles_o=35 if enabled.
- Mode 1, coef=0xFF, word lanes all 0xFF, N=1 -> d_b1_o = 0xFE01 in every lane; exactly one write.
- Mode 3, coef=0x10, src=0xFE, dst=0xFF, N=3 -> reads at FE, FF, 00 and writes at FF, 00, 01; lane 0xF5 gives 0x0105.
- run_count_i=0 -> no ce_b0_o/ce_b1_o activity; done_o one cycle later. run_count_i=257 -> err_o pulse, idle_o stays 1, no done_o.
- RD_LATENCY=2, N=4 -> writes in cycles 4..7 and done_o in cycle 8. A start pulse during RUN is ignored.
- reset_n low during write 10 of 32 -> all outputs 0 asynchronously. A fresh start after release runs normally from k=0.
